// File: rtl/ram_bist_ctrl.sv
// Built-in self-test master for a single-port block RAM: writes a seeded pattern, reads it back and checks.
// Defining RAM_BIST_INVERT_PASS_EN adds a second WRITE/READ/DRAIN pass using the inverted pattern.
module ram_bist_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);
    localparam int                DRN_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Test pattern: address plus seed, optionally inverted for the second pass.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic              inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) + s;
        if (inv) begin
            pattern = ~p;
        end else begin
            pattern = p;
        end
    endfunction

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DRN_W-1:0]  drn_r, drn_nxt_s;
    logic [DATA_W-1:0] seed_r, seed_nxt_s;
    logic [ERR_W-1:0]  err_r, err_nxt_s;
    logic [ADDR_W-1:0] ferr_r, ferr_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              pass_r, pass_nxt_s;
    logic              en_r, en_nxt_s;
    logic              we_r, we_nxt_s;
    logic [DATA_W-1:0] wd_r, wd_nxt_s;
    logic              inv_s;
`ifdef RAM_BIST_INVERT_PASS_EN
    logic              sel_r, sel_nxt_s;
    assign inv_s = sel_r;
`else
    assign inv_s = 1'b0;
`endif

    logic [RD_LAT-1:0] pipe_vld_r;
    logic [ADDR_W-1:0] pipe_addr_r [RD_LAT];
    logic [ADDR_W-1:0] cmp_addr_s;
    logic              mismatch_s;

    // Compare point: the pipeline tail lines up with douta for the read it tracks.
    assign cmp_addr_s = pipe_addr_r[RD_LAT-1];
    assign mismatch_s = pipe_vld_r[RD_LAT-1] && (ram_rd_data != pattern(cmp_addr_s, seed_r, inv_s));

    // Next-state, error accounting and next values for the registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        drn_nxt_s   = drn_r;
        seed_nxt_s  = seed_r;
        err_nxt_s   = err_r;
        ferr_nxt_s  = ferr_r;
        done_nxt_s  = 1'b0;
        pass_nxt_s  = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
        sel_nxt_s   = sel_r;
`endif
        if (mismatch_s) begin
            if (err_r == '0) begin
                ferr_nxt_s = cmp_addr_s;
            end else begin
                ferr_nxt_s = ferr_r;
            end
            if (err_r != ERR_MAX) begin
                err_nxt_s = err_r + 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
        end else begin
            err_nxt_s = err_r;
        end

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt_s = S_WRITE;
                    addr_nxt_s  = '0;
                    seed_nxt_s  = seed;
                    err_nxt_s   = '0;
                    ferr_nxt_s  = '0;
`ifdef RAM_BIST_INVERT_PASS_EN
                    sel_nxt_s   = 1'b0;
`endif
                end else begin
                    // Status is published from the settled error count one cycle after DONE is entered.
                    done_nxt_s = (state_r == S_DONE);
                    pass_nxt_s = (state_r == S_DONE) && (err_r == '0);
                end
            end
            S_WRITE: begin
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = S_READ;
                    addr_nxt_s  = '0;
                end else begin
                    addr_nxt_s  = addr_r + 1'b1;
                end
            end
            S_READ: begin
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = S_DRAIN;
                    addr_nxt_s  = '0;
                    drn_nxt_s   = '0;
                end else begin
                    addr_nxt_s  = addr_r + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn_r == DRN_LAST) begin
`ifdef RAM_BIST_INVERT_PASS_EN
                    if (!sel_r) begin
                        state_nxt_s = S_WRITE;
                        addr_nxt_s  = '0;
                        sel_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = S_DONE;
                    end
`else
                    state_nxt_s = S_DONE;
`endif
                end else begin
                    drn_nxt_s = drn_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase

        en_nxt_s   = (state_nxt_s == S_WRITE) || (state_nxt_s == S_READ);
        we_nxt_s   = (state_nxt_s == S_WRITE);
        busy_nxt_s = en_nxt_s || (state_nxt_s == S_DRAIN);
        if (we_nxt_s) begin
`ifdef RAM_BIST_INVERT_PASS_EN
            wd_nxt_s = pattern(addr_nxt_s, seed_nxt_s, sel_nxt_s);
`else
            wd_nxt_s = pattern(addr_nxt_s, seed_nxt_s, 1'b0);
`endif
        end else begin
            wd_nxt_s = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= '0;
            drn_r   <= '0;
            seed_r  <= '0;
            err_r   <= '0;
            ferr_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            en_r    <= 1'b0;
            we_r    <= 1'b0;
            wd_r    <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
            sel_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            drn_r   <= drn_nxt_s;
            seed_r  <= seed_nxt_s;
            err_r   <= err_nxt_s;
            ferr_r  <= ferr_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            pass_r  <= pass_nxt_s;
            en_r    <= en_nxt_s;
            we_r    <= we_nxt_s;
            wd_r    <= wd_nxt_s;
`ifdef RAM_BIST_INVERT_PASS_EN
            sel_r   <= sel_nxt_s;
`endif
        end
    end

    // Read-tracking pipeline: one stage per cycle of RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= en_r && !we_r;
            pipe_addr_r[0] <= addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_r;
    assign first_err_addr = ferr_r;
    assign ram_en         = en_r;
    assign ram_we         = we_r;
    assign ram_addr       = addr_r;
    assign ram_wr_data    = wd_r;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with fault injection, spec-level expected-result model.
module tb_ram_bist_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int ERR_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int NPASS  = 2;
`else
    localparam int NPASS  = 1;
`endif
    localparam int DONE_LAT = NPASS * (2 * DEPTH + RD_LAT) + 1;
    localparam int LIMIT    = 400;
    localparam int LOGN     = NPASS * DEPTH + 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              start4 = 1'b0;
    logic [DATA_W-1:0] seed = '0;

    logic              busy, done, pass, ram_en, ram_we;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr, ram_addr;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

    logic              busy4, done4, pass4, en4, we4;
    logic [3:0]        err4;
    logic [ADDR_W-1:0] fea4, addr4;
    logic [DATA_W-1:0] wd4, rd4;

    int checks = 0;
    int errors = 0;

    bit flt_en = 1'b0;
    int flt_addr = 0;
    int flt_bit = 0;
    bit flt_val = 1'b0;

    logic [DATA_W-1:0] wlog_d [LOGN];
    int                wlog_a [LOGN];
    int n_wr, n_en, first_en, lat;
    logic busy0, done0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .seed(seed),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .first_err_addr(fea4),
        .ram_en(en4), .ram_we(we4), .ram_addr(addr4), .ram_wr_data(wd4),
        .ram_rd_data(rd4)
    );

    function automatic logic [DATA_W-1:0] pat(input int a, input int s, input bit inv);
        int v;
        v = ((a % (1 << DATA_W)) + s) % (1 << DATA_W);
        return inv ? ~DATA_W'(v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] stuck(input logic [DATA_W-1:0] d, input int a, input bit en,
                                                input int fa, input int b, input bit v);
        logic [DATA_W-1:0] r;
        r = d;
        if (en && a == fa) r[b] = v;
        return r;
    endfunction

    // Ideal RAMs with RD_LAT latency; the first has a stuck bit, the second returns inverted data.
    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] mem4 [DEPTH];
    logic [DATA_W-1:0] rdq  [RD_LAT];
    logic [DATA_W-1:0] rdq4 [RD_LAT];
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
        rdq[0] <= (ram_en && !ram_we) ?
                  stuck(mem[ram_addr], int'(ram_addr), flt_en, flt_addr, flt_bit, flt_val) : '0;
        if (en4 && we4) mem4[addr4] <= wd4;
        rdq4[0] <= (en4 && !we4) ? ~mem4[addr4] : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            rdq[i]  <= rdq[i-1];
            rdq4[i] <= rdq4[i-1];
        end
    end
    assign ram_rd_data = rdq[RD_LAT-1];
    assign rd4         = rdq4[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the pattern rule and fault description alone.
    task automatic model(input logic [DATA_W-1:0] s, output int e, output int fa);
        logic [DATA_W-1:0] w;
        e = 0;
        fa = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = pat(a, int'(s), p == 1);
                if (stuck(w, a, flt_en, flt_addr, flt_bit, flt_val) !== w) begin
                    if (e == 0) fa = a;
                    e++;
                end
            end
        end
        if (e > (1 << ERR_W) - 1) e = (1 << ERR_W) - 1;
    endtask

    task automatic run_test(input logic [DATA_W-1:0] s);
        seed = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_wr = 0; n_en = 0; first_en = -1; lat = -1;
        busy0 = busy; done0 = done;
        for (int c = 1; c <= LIMIT; c++) begin
            if (ram_en) begin
                if (first_en < 0) first_en = c - 1;
                n_en++;
            end
            if (ram_en && ram_we && n_wr < LOGN) begin
                wlog_d[n_wr] = ram_wr_data;
                wlog_a[n_wr] = int'(ram_addr);
                n_wr++;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic verify_run(input string tag, input logic [DATA_W-1:0] s);
        int e, fa, bad;
        model(s, e, fa);
        run_test(s);
        check({tag, " busy_at_T0"}, {busy0, done0}, 32'd2);
        check({tag, " latency"}, lat, DONE_LAT);
        check({tag, " first_en"}, first_en, 32'd0);
        check({tag, " en_cycles"}, n_en, 2 * NPASS * DEPTH);
        check({tag, " wr_count"}, n_wr, NPASS * DEPTH);
        bad = 0;
        for (int i = 0; i < n_wr; i++) begin
            if (wlog_a[i] != i % DEPTH || wlog_d[i] !== pat(i % DEPTH, int'(s), i >= DEPTH)) bad++;
        end
        check({tag, " wr_bad"}, bad, 32'd0);
        check({tag, " err_cnt"}, err_cnt, e);
        check({tag, " first_err"}, first_err_addr, fa);
        check({tag, " pass"}, pass, (e == 0) ? 32'd1 : 32'd0);
        check({tag, " idle_ram"}, {busy, ram_en, ram_we, ram_addr, ram_wr_data}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_en = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ram_en) n_en++;
        end
        check("rst status", {busy, done, pass, err_cnt, first_err_addr}, 32'd0);
        check("rst ram", {ram_en, ram_we, ram_addr, ram_wr_data}, 32'd0);
        check("rst en_seen", n_en, 32'd0);
        check("rst dut4", {busy4, done4, pass4, err4, fea4, en4}, 32'd0);

        verify_run("seed00", 8'h00);
        check("seed00 addr5", wlog_d[5], 32'h05);
        verify_run("seedA5", 8'hA5);
        check("seedA5 addr31", wlog_d[31], 32'hC4);
        check("seedA5 addr0", wlog_d[0], 32'hA5);

        flt_en = 1'b1; flt_addr = 7; flt_bit = 0; flt_val = 1'b1;
        verify_run("stuck7_s01", 8'h01);
        verify_run("stuck7_s00", 8'h00);
        flt_addr = 3; flt_val = 1'b0;
        verify_run("stuck3_s00", 8'h00);

        for (int k = 0; k < 6; k++) begin
            flt_en   = ($urandom_range(0, 1) == 1);
            flt_addr = int'($urandom_range(0, DEPTH - 1));
            flt_bit  = int'($urandom_range(0, DATA_W - 1));
            flt_val  = ($urandom_range(0, 1) == 1);
            verify_run("random", DATA_W'($urandom));
        end
        flt_en = 1'b0;

        verify_run("seed10", 8'h10);
        check("seed10 addr3 last pass", wlog_d[(NPASS - 1) * DEPTH + 3], pat(3, 16, NPASS == 2));

        // Start mid-run is ignored, then a reset aborts the run.
        seed = 8'h33; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
        seed = 8'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored start busy", {busy, done}, 32'd2);
        check("ignored start addr", ram_addr, 32'd10);
        check("ignored start data", ram_wr_data, pat(10, 8'h33, 1'b0));
        for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort state", {busy, done, pass, ram_en, err_cnt}, 32'd0);
        rst_n = 1'b1;
        verify_run("after_abort", 8'h5A);

        // Start coinciding with reset: reset wins.
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rst_vs_start", {busy, done, ram_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_vs_start after", {busy, ram_en}, 32'd0);

        // Narrow counter with every read corrupted saturates.
        seed = 8'h3C; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = -1;
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = c;
                break;
            end
        end
        check("sat latency", lat, DONE_LAT);
        check("sat err_cnt", err4, 32'd15);
        check("sat first_err", fea4, 32'd0);
        check("sat pass", pass4, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
